// File: rtl/encoder_pkg.sv
// Shared encoder constants: result-vector geometry, pipeline latency and
// the serializer FSM state encoding.
`timescale 1ns/1ps
package encoder_pkg;

  localparam int ENC_BITSIZE  = 32;
  localparam int ENC_M_OUTPUT = 4;
  localparam int ENC_LATENCY  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that tracks the encoder pipeline: strobe is in_valid
// delayed by LATENCY cycles.
`timescale 1ns/1ps
module valid_delay_line #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic strobe
);

  logic [LATENCY-1:0] vpipe_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_reg <= '0;
    end else begin
      vpipe_reg[0] <= in_valid;
      for (int k = LATENCY - 1; k > 0; k--) begin
        vpipe_reg[k] <= vpipe_reg[k-1];
      end
    end
  end

  assign strobe = vpipe_reg[LATENCY-1];

endmodule

// File: rtl/encoder_output_serializer.sv
// Captures the encoder result vector when the delayed valid fires, applies
// optional ReLU and streams the words out over valid/ready.
`timescale 1ns/1ps
module encoder_output_serializer
  import encoder_pkg::*;
#(
  parameter int M_output = ENC_M_OUTPUT,
  parameter int BITSIZE  = ENC_BITSIZE,
  parameter int LATENCY  = ENC_LATENCY,
  parameter bit RELU_EN  = 1'b1,
  localparam int IDX_W   = (M_output > 1) ? $clog2(M_output) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [M_output*BITSIZE-1:0] enc_out,
  output logic [BITSIZE-1:0]          out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [IDX_W-1:0]            out_index,
  output logic                        busy,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [BITSIZE-1:0] buf_reg   [M_output];
  logic [BITSIZE-1:0] relu_word [M_output];
  logic               overflow_reg;
  logic [15:0]        drop_count_reg;
  logic               strobe;
  logic               capture;
  logic               drop;
  logic               handshake;
  logic               last_word;

  valid_delay_line #(
    .LATENCY(LATENCY)
  ) u_valid_delay_line (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .strobe   (strobe)
  );

  genvar gi;
  generate
    for (gi = 0; gi < M_output; gi++) begin : g_relu
      assign relu_word[gi] = (RELU_EN && enc_out[(gi+1)*BITSIZE-1]) ?
                             '0 : enc_out[gi*BITSIZE +: BITSIZE];
    end
  endgenerate

  assign last_word = (idx_reg == IDX_W'(M_output - 1));
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (strobe) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake && !last_word) begin
          idx_next = idx_reg + IDX_W'(1);
        end
        // Last word leaving on the same edge as a new strobe frees the
        // buffer just in time, so the new vector is taken without a bubble.
        if (handshake && last_word) begin
          if (strobe) begin
            capture  = 1'b1;
            idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else if (strobe) begin
          drop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < M_output; j++) begin
        buf_reg[j] <= '0;
      end
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (capture) begin
        for (int j = 0; j < M_output; j++) begin
          buf_reg[j] <= relu_word[j];
        end
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end
    end
  end

  always_comb begin
    out_valid = (state_reg == SEND);
    out_data  = out_valid ? buf_reg[idx_reg] : '0;
    out_index = idx_reg;
    out_last  = out_valid && last_word;
    busy      = (state_reg == SEND);
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_encoder_output_serializer.sv
// Directed bench for encoder_output_serializer: ReLU on/off, back-to-back
// vectors, backpressure drops, ready toggling and asynchronous reset.
`timescale 1ns/1ps
module tb_encoder_output_serializer;
  import encoder_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] xin = '0;
  logic [127:0] enc_d1 = '0;
  logic [127:0] enc_out = '0;

  logic [31:0]  out_data, nr_out_data;
  logic         out_valid, nr_out_valid;
  logic         out_last, nr_out_last;
  logic [1:0]   out_index, nr_out_index;
  logic         busy, nr_busy;
  logic         overflow, nr_overflow;
  logic [15:0]  drop_count, nr_drop_count;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] V1 = {32'h7FFFFFFF, 32'h00000000, 32'hFFFF0000, 32'h00010000};
  localparam logic [127:0] V2 = {32'h12345678, 32'hFFFFFFFF, 32'h00000005, 32'h80000000};
  localparam logic [127:0] V3 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  logic [31:0] v1_relu [4] = '{32'h00010000, 32'h00000000, 32'h00000000, 32'h7FFFFFFF};
  logic [31:0] v1_raw  [4] = '{32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h7FFFFFFF};
  logic [31:0] v23_exp [8] = '{32'h00000000, 32'h00000005, 32'h00000000, 32'h12345678,
                               32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  always #5 clk = ~clk;

  // Stand-in for the two-stage encoder: result appears LATENCY edges later.
  always @(posedge clk) begin
    enc_d1  <= xin;
    enc_out <= enc_d1;
  end

  encoder_output_serializer #(.RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .enc_out(enc_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index), .busy(busy),
    .overflow(overflow), .drop_count(drop_count)
  );

  encoder_output_serializer #(.RELU_EN(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .enc_out(enc_out),
    .out_data(nr_out_data), .out_valid(nr_out_valid), .out_ready(out_ready),
    .out_last(nr_out_last), .out_index(nr_out_index), .busy(nr_busy),
    .overflow(nr_overflow), .drop_count(nr_drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_index"}, 32'(out_index), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_drops"}, 32'(drop_count), 32'd0);
    chk({tag, "_nr_any"}, 32'({nr_out_valid, nr_out_last, nr_busy, nr_overflow, nr_out_index}), 32'd0);
    chk({tag, "_nr_data"}, nr_out_data ^ 32'(nr_drop_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    xin       = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset(tag);
  endtask

  task automatic check_word(input string tag, input logic [31:0] exp, input int idx);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_index"}, 32'(out_index), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(idx == 3));
  endtask

  initial begin
    // Single vector, ready high, both ReLU settings.
    do_reset("rst1");
    out_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      in_valid = (c == 0);
      xin      = (c == 0) ? V1 : '0;
      tick();
      if (c < 2) begin
        chk("s1_early_valid", 32'(out_valid), 32'd0);
      end else if (c < 6) begin
        check_word("s1", v1_relu[c-2], c - 2);
        chk("s1_nr_data", nr_out_data, v1_raw[c-2]);
        chk("s1_nr_index", 32'(nr_out_index), 32'(c - 2));
        $display("xfer s1 idx %0d data %h nr %h last %0b", out_index, out_data, nr_out_data, out_last);
      end else begin
        chk("s1_idle_valid", 32'(out_valid), 32'd0);
        chk("s1_idle_busy", 32'(busy), 32'd0);
      end
    end

    // Two vectors four cycles apart: eight words with no bubble.
    do_reset("rst2");
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      in_valid = (c == 0) || (c == 4);
      if (c == 0) xin = V2;
      if (c == 4) xin = V3;
      tick();
      if (c >= 2 && c < 10) begin
        check_word("s2", v23_exp[c-2], (c - 2) % 4);
        $display("xfer s2 idx %0d data %h last %0b", out_index, out_data, out_last);
      end else if (c == 10) begin
        chk("s2_idle_valid", 32'(out_valid), 32'd0);
      end
    end
    chk("s2_ovf", 32'(overflow), 32'd0);
    chk("s2_drops", 32'(drop_count), 32'd0);

    // Backpressure: second result dropped, first held stable then sent.
    do_reset("rst3");
    for (int c = 0; c <= 16; c++) begin
      in_valid  = (c == 0) || (c == 1);
      xin       = (c == 0) ? V1 : V2;
      out_ready = (c >= 13);
      tick();
      if (c >= 2 && c <= 15) begin
        check_word("s3", v1_relu[(c <= 12) ? 0 : c - 12], (c <= 12) ? 0 : c - 12);
        if (c >= 12) $display("xfer s3 idx %0d data %h last %0b", out_index, out_data, out_last);
      end else if (c == 16) begin
        chk("s3_idle_valid", 32'(out_valid), 32'd0);
      end
    end
    chk("s3_ovf", 32'(overflow), 32'd1);
    chk("s3_drops", 32'(drop_count), 32'd1);

    // Ready toggling every cycle: each word held until accepted, in order.
    do_reset("rst4");
    begin
      int  exp_idx;
      bit  sending;
      bit  rdy;
      exp_idx = 0;
      sending = 1'b0;
      for (int c = 0; c <= 14; c++) begin
        in_valid  = (c == 0);
        xin       = (c == 0) ? V3 : '0;
        rdy       = (c % 2) == 1;
        out_ready = rdy;
        tick();
        if (sending && rdy) begin
          if (exp_idx == 3) sending = 1'b0;
          else exp_idx++;
        end
        if (c == 2) begin
          sending = 1'b1;
          exp_idx = 0;
        end
        chk("s4_valid", 32'(out_valid), 32'(sending));
        if (sending) begin
          chk("s4_data", out_data, v23_exp[4 + exp_idx]);
          chk("s4_index", 32'(out_index), 32'(exp_idx));
        end
      end
    end

    // Asynchronous reset mid-vector with another result in flight.
    do_reset("rst5");
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      in_valid = (c == 0) || (c == 3);
      xin      = (c == 0) ? V1 : V2;
      tick();
    end
    in_valid = 1'b0;
    chk("s5_pre_index", 32'(out_index), 32'd2);
    #2 rst = 1'b1;
    #1 check_reset("s5_async");
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("s5_post_valid", 32'(out_valid), 32'd0);
    end
    chk("s5_post_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_output_serializer.md
# encoder_output_serializer

Sits directly downstream of the fixed-point encoder. Tracks the encoder's fixed pipeline latency with a valid delay line and captures the parallel `M_output`-word result vector when it is valid. Applies optional ReLU per word, then streams the words one at a time over a valid/ready interface to the next layer or the host, flagging results dropped under backpressure.

## Interface
Parameters:
- `M_output`, 4, number of encoder output words per result vector
- `BITSIZE`, 32, fixed-point word width (two's complement)
- `LATENCY`, 2, encoder register stages between input presentation and valid `out`; must be ≥ 1
- `RELU_EN`, 1, 1 = clamp negative words to 0; 0 = pass through

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge
- `rst`, in, 1, asynchronous, active-high reset
- `in_valid`, in, 1, high in the cycle the encoder's `x`/`w` inputs are presented, i.e. sampled by the encoder on the same edge
- `enc_out`, in, `M_output*BITSIZE`, encoder result vector; word j occupies bits `[(j+1)*BITSIZE-1 : j*BITSIZE]`
- `out_data`, out, `BITSIZE`, current serialized word
- `out_valid`, out, 1, `out_data` is valid
- `out_ready`, in, 1, consumer accepts the word
- `out_last`, out, 1, high with the word of index `M_output-1`
- `out_index`, out, `$clog2(M_output)`, index of the current word
- `busy`, out, 1, a captured vector is not fully sent
- `overflow`, out, 1, sticky; a result was dropped
- `drop_count`, out, 16, saturating count of dropped results

## Operation
- Delay line `vpipe[0:LATENCY-1]`: `vpipe[0]<=in_valid`, `vpipe[k]<=vpipe[k-1]`. The strobe is `vpipe[LATENCY-1]`. When the strobe is high, `enc_out` holds the result of that input.
- Capture on an edge where the strobe is high and the buffer can accept. Per word: `buf[j] = (RELU_EN && enc_out_j[BITSIZE-1]) ? 0 : enc_out_j`.
- FSM has two states, IDLE and SEND.
  - IDLE, strobe high: capture, set `idx=0`, go to SEND.
  - SEND: `out_valid=1`, `out_data=buf[idx]`, `out_index=idx`, `out_last=(idx==M_output-1)`. A handshake is `out_valid && out_ready`.
  - SEND, handshake with `idx<M_output-1`: increment `idx`.
  - SEND, handshake on the last word with no strobe: go to IDLE.
  - SEND, handshake on the last word with the strobe high in the same cycle: capture the new vector, set `idx=0`, stay in SEND. There is no bubble, so back-to-back vectors are lossless.
  - SEND, strobe high without a last-word handshake: drop the new result. Set `overflow`; increment `drop_count`, saturating at 0xFFFF. The buffer and `idx` are unchanged.
- While `out_valid` is high, `out_data`/`out_index`/`out_last` stay stable until the handshake.
- `busy` = (state == SEND).
- No arithmetic apart from the sign test. Widths are preserved bit-exactly.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`, `busy=0`, `overflow=0`, `drop_count=0`, `vpipe` all 0, state IDLE, buffer 0.
- Latency, with `in_valid` sampled at edge E0:
  - the strobe is high in the cycle after edge E(LATENCY-1);
  - capture happens at edge E(LATENCY);
  - first `out_valid` is visible after E(LATENCY): after E2 for the default.
- With `out_ready` held high, word j is accepted at edge E(LATENCY+1+j), so `out_last` is accepted at E(LATENCY+M_output).
- Sustained throughput is one vector per `M_output` cycles. `in_valid` arriving more often than that causes drops.
- Reset mid-operation: all state clears asynchronously, and in-flight `vpipe` results and the partial vector are discarded. No output is produced for inputs presented before reset deasserts.
- Simultaneous `in_valid` and strobe: independent; the delay line always shifts.

## Structure
- A shared package `encoder_pkg` holds `BITSIZE`, `M_output`, the encoder `LATENCY` constant, and the FSM state encoding (IDLE=0, SEND=1). The encoder and this block use the same latency constant.
- One natural sub-module, `valid_delay_line` (parameter `LATENCY`): the `vpipe` shift register with async reset.
- The ReLU/capture logic and the FSM stay in the top module.

## Test plan
- Reset, then one `in_valid` with `enc_out` words {0x00010000, 0xFFFF0000, 0x00000000, 0x7FFFFFFF}, `RELU_EN=1`, `out_ready=1` -> `out_valid` rises after E2. Outputs are 0x00010000, 0x00000000, 0x00000000, 0x7FFFFFFF at indices 0..3, with `out_last` only on index 3.
- Same stimulus with `RELU_EN=0` -> word 1 is 0xFFFF0000.
- Two `in_valid` exactly 4 cycles apart with `out_ready=1` -> 8 consecutive words with no bubble; `overflow=0`.
- `out_ready=0` for 10 cycles after the first capture, with a second `in_valid` 1 cycle after the first -> the first vector is held stable and sent intact; `overflow=1`, `drop_count=1`.
- Toggle `out_ready` every cycle -> each word is held until accepted, and the order is 0,1,2,3.
- Assert `rst` mid-SEND at index 2, with a third `in_valid` in flight -> all outputs return to reset values immediately, and no words appear after release.
